// File: rtl/ascii_pkg.sv
// Shared constants and types for the ASCII hex token parser.
package ascii_pkg;

    localparam logic [7:0] ASCII_SPACE  = 8'h20;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_COMMA  = 8'h2C;

    localparam logic [7:0] ASCII_0      = 8'h30;
    localparam logic [7:0] ASCII_9      = 8'h39;
    localparam logic [7:0] ASCII_UA     = 8'h41;
    localparam logic [7:0] ASCII_UF     = 8'h46;
    localparam logic [7:0] ASCII_LA     = 8'h61;
    localparam logic [7:0] ASCII_LF_HEX = 8'h66;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        EMIT,
        DISCARD
    } parser_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_INVALID  = 2'b01,
        ERR_OVERFLOW = 2'b10
    } parse_err_t;

    function automatic logic in_range(input logic [7:0] c, input logic [7:0] lo,
                                      input logic [7:0] hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/ascii_to_nibble.sv
// Combinational ASCII character classifier and hex-digit decoder.
// ASCII_HEX_LOWERCASE_EN: when defined, 'a'-'f' also decode as hex digits.
module ascii_to_nibble
    import ascii_pkg::*;
(
    input  logic [7:0] char,
    output logic [3:0] nibble,
    output logic       is_digit,
    output logic       is_delim
);

    always_comb begin
        nibble   = 4'h0;
        is_digit = 1'b0;
        is_delim = 1'b0;
        if (in_range(char, ASCII_0, ASCII_9)) begin
            is_digit = 1'b1;
            nibble   = char[3:0];
        end else if (in_range(char, ASCII_UA, ASCII_UF)) begin
            // 'A' is 0x41, so the low nibble plus 9 gives 0xA..0xF.
            is_digit = 1'b1;
            nibble   = char[3:0] + 4'd9;
`ifdef ASCII_HEX_LOWERCASE_EN
        end else if (in_range(char, ASCII_LA, ASCII_LF_HEX)) begin
            is_digit = 1'b1;
            nibble   = char[3:0] + 4'd9;
`endif
        end else if (char == ASCII_SPACE || char == ASCII_CR ||
                     char == ASCII_LF || char == ASCII_COMMA) begin
            is_delim = 1'b1;
        end
    end

endmodule

// File: rtl/ascii_hex_parser.sv
// Streaming ASCII hex token parser: accumulates hex digits, emits the word on a delimiter.
// Lowercase digit support is selected with ASCII_HEX_LOWERCASE_EN (see ascii_to_nibble).
module ascii_hex_parser
    import ascii_pkg::*;
#(
    parameter int unsigned DIGITS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [7:0]                   in_char,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [4*DIGITS-1:0]          out_data,
    output logic [$clog2(DIGITS+1)-1:0]  out_count,
    output logic                         err,
    output logic [1:0]                   err_code
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS + 1);

    parser_state_t state_q;
    logic [W-1:0]  acc_q;
    logic [CW-1:0] count_q;

    logic [3:0] nibble;
    logic       is_digit;
    logic       is_delim;
    logic       xfer;

    ascii_to_nibble u_nibble (
        .char     (in_char),
        .nibble   (nibble),
        .is_digit (is_digit),
        .is_delim (is_delim)
    );

    assign in_ready = (state_q != EMIT);
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            count_q   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            err <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (xfer) begin
                        if (is_digit) begin
                            acc_q   <= W'(nibble);
                            count_q <= CW'(1);
                            state_q <= ACCUM;
                        end else if (!is_delim) begin
                            err      <= 1'b1;
                            err_code <= ERR_INVALID;
                            state_q  <= DISCARD;
                        end
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        if (is_digit) begin
                            if (count_q == CW'(DIGITS)) begin
                                // Overflowed token is dropped, never emitted truncated.
                                err      <= 1'b1;
                                err_code <= ERR_OVERFLOW;
                                acc_q    <= '0;
                                count_q  <= '0;
                                state_q  <= DISCARD;
                            end else begin
                                acc_q   <= (acc_q << 4) | W'(nibble);
                                count_q <= count_q + CW'(1);
                            end
                        end else if (is_delim) begin
                            out_valid <= 1'b1;
                            out_data  <= acc_q;
                            out_count <= count_q;
                            state_q   <= EMIT;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_INVALID;
                            acc_q    <= '0;
                            count_q  <= '0;
                            state_q  <= DISCARD;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc_q     <= '0;
                        count_q   <= '0;
                        state_q   <= IDLE;
                    end
                end
                DISCARD: begin
                    if (xfer && is_delim) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Self-checking bench for ascii_hex_parser: vector table, hand-written timing cases,
// and a randomized token stream checked against a token-level reference model.
module tb_ascii_hex_parser;

    localparam int unsigned DIGITS = 8;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic [7:0]  in_char   = 8'h00;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_count;
    logic        err;
    logic [1:0]  err_code;

    int n_cmp = 0;
    int n_bad = 0;

    logic [35:0] obs_w[$];
    logic [35:0] exp_w[$];
    logic [1:0]  obs_e[$];
    logic [1:0]  exp_e[$];
    bit          rnd_ready = 1'b0;

    typedef struct {
        string       s;
        int          nw;
        logic [31:0] data;
        int          cnt;
        int          ne;
        logic [1:0]  code;
    } vec_t;

    ascii_hex_parser #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_char   (in_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic vec_t mk(input string s, input int nw, input logic [31:0] data,
                                input int cnt, input int ne, input logic [1:0] code);
        vec_t v;
        v.s = s; v.nw = nw; v.data = data; v.cnt = cnt; v.ne = ne; v.code = code;
        return v;
    endfunction

    // Reference: split the stream into delimiter-separated tokens and judge each token whole.
    function automatic int hexval(input byte c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
`ifdef ASCII_HEX_LOWERCASE_EN
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
`endif
        return -1;
    endfunction

    function automatic bit is_delim_ref(input byte c);
        return c == 8'h20 || c == 8'h0D || c == 8'h0A || c == 8'h2C;
    endfunction

    function automatic void model(input byte q[$]);
        byte   tok[$];
        for (int i = 0; i < q.size(); i++) begin
            if (!is_delim_ref(q[i])) begin
                tok.push_back(q[i]);
            end else if (tok.size() > 0) begin
                longint unsigned v = 0;
                bit bad = 1'b0;
                for (int k = 0; k < tok.size() && !bad; k++) begin
                    if (hexval(tok[k]) < 0) begin
                        exp_e.push_back(2'b01);
                        bad = 1'b1;
                    end else if (k >= DIGITS) begin
                        exp_e.push_back(2'b10);
                        bad = 1'b1;
                    end else begin
                        v = v * 16 + longint'(hexval(tok[k]));
                    end
                end
                if (!bad) exp_w.push_back({4'(tok.size()), 32'(v)});
                tok.delete();
            end
        end
    endfunction

    initial begin : monitor
        bit          hold_pending = 1'b0;
        logic [35:0] held = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid && hold_pending)
                    check("emit_stable", 64'({out_count, out_data}), 64'(held));
                if (out_valid && out_ready) obs_w.push_back({out_count, out_data});
                hold_pending = out_valid && !out_ready;
                held         = {out_count, out_data};
                if (err) obs_e.push_back(err_code);
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL global_timeout: actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic send_char(input byte c);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_char  = c;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        obs_w.delete(); obs_e.delete(); exp_w.delete(); exp_e.delete();
    endtask

    initial begin : stim
        vec_t tbl[$];
        byte  stream[$];
        string hexs, lows, dels, bads;

        tbl.push_back(mk("1A3F\r", 1, 32'h1A3F, 4, 0, 2'b00));
        tbl.push_back(mk("123456789,7\n", 1, 32'h7, 1, 1, 2'b10));
        tbl.push_back(mk("1G2 5 ", 1, 32'h5, 1, 1, 2'b01));
`ifdef ASCII_HEX_LOWERCASE_EN
        tbl.push_back(mk("ff\n", 1, 32'hFF, 2, 0, 2'b00));
`else
        tbl.push_back(mk("ff\n", 0, 32'h0, 0, 1, 2'b01));
`endif
        tbl.push_back(mk("  ,\r\n", 0, 32'h0, 0, 0, 2'b00));
        tbl.push_back(mk("12345678 ", 1, 32'h12345678, 8, 0, 2'b00));
        tbl.push_back(mk("0\n", 1, 32'h0, 1, 0, 2'b00));
        tbl.push_back(mk("Z 9,", 1, 32'h9, 1, 1, 2'b01));
        tbl.push_back(mk("00C0FFEE\r", 1, 32'h00C0FFEE, 8, 0, 2'b00));

        // Reset values.
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table, consumer always ready.
        out_ready = 1'b1;
        foreach (tbl[t]) begin
            clear_q();
            send_str(tbl[t].s);
            drain();
            check({"tbl_nwords ", tbl[t].s}, 64'(obs_w.size()), 64'(tbl[t].nw));
            check({"tbl_nerrs ", tbl[t].s}, 64'(obs_e.size()), 64'(tbl[t].ne));
            if (tbl[t].nw > 0 && obs_w.size() > 0) begin
                check({"tbl_data ", tbl[t].s}, 64'(obs_w[0][31:0]), 64'(tbl[t].data));
                check({"tbl_count ", tbl[t].s}, 64'(obs_w[0][35:32]), 64'(tbl[t].cnt));
            end
            if (tbl[t].ne > 0 && obs_e.size() > 0)
                check({"tbl_code ", tbl[t].s}, 64'(obs_e[0]), 64'(tbl[t].code));
        end

        // Backpressure: word held in EMIT, input stalled, next byte taken after handshake.
        clear_q();
        out_ready = 1'b0;
        send_str("DEADBEEF ");
        @(negedge clk);
        check("lat_out_valid", 64'(out_valid), 64'd1);
        check("lat_in_ready", 64'(in_ready), 64'd0);
        check("lat_data", 64'(out_data), 64'hDEADBEEF);
        check("lat_count", 64'(out_count), 64'd8);
        repeat (5) begin
            @(negedge clk);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'(out_data), 64'hDEADBEEF);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_char  = 8'h33;
        repeat (2) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_hs_in_ready", 64'(in_ready), 64'd1);
        check("post_hs_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        in_char = 8'h20;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        check("bp_nwords", 64'(obs_w.size()), 64'd2);
        if (obs_w.size() == 2) begin
            check("bp_word0", 64'(obs_w[0]), 64'({4'd8, 32'hDEADBEEF}));
            check("bp_word1", 64'(obs_w[1]), 64'({4'd1, 32'h3}));
        end

        // Overflow error pulse timing and recovery.
        clear_q();
        send_str("12345678");
        send_char(8'h39);
        in_valid = 1'b0;
        @(negedge clk);
        check("ovf_err_pulse", 64'(err), 64'd1);
        check("ovf_err_code", 64'(err_code), 64'd2);
        @(negedge clk);
        check("ovf_err_clear", 64'(err), 64'd0);
        check("ovf_code_held", 64'(err_code), 64'd2);
        @(posedge clk);
        #1;
        send_str(",7\n");
        drain();
        check("ovf_nwords", 64'(obs_w.size()), 64'd1);
        if (obs_w.size() == 1) check("ovf_next_word", 64'(obs_w[0]), 64'({4'd1, 32'h7}));

        // Reset mid-token.
        clear_q();
        send_str("AB");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_err_code", 64'(err_code), 64'd0);
        check("mid_rst_out_data", 64'(out_data), 64'd0);
        check("mid_rst_out_count", 64'(out_count), 64'd0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_str("C\r");
        drain();
        check("mid_rst_nwords", 64'(obs_w.size()), 64'd1);
        if (obs_w.size() == 1) check("mid_rst_word", 64'(obs_w[0]), 64'({4'd1, 32'hC}));

        // Reset during EMIT.
        clear_q();
        out_ready = 1'b0;
        send_str("5 ");
        @(negedge clk);
        check("emit_rst_pre_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("emit_rst_out_valid", 64'(out_valid), 64'd0);
        check("emit_rst_in_ready", 64'(in_ready), 64'd1);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_str("E\n");
        drain();
        check("emit_rst_nwords", 64'(obs_w.size()), 64'd1);
        if (obs_w.size() == 1) check("emit_rst_word", 64'(obs_w[0]), 64'({4'd1, 32'hE}));

        // Randomized token stream with random gaps and random consumer stalls.
        clear_q();
        hexs = "0123456789ABCDEF";
        lows = "abcdef";
        dels = " \r\n,";
        bads = "GZz!:@/`g~";
        for (int t = 0; t < 150; t++) begin
            int len;
            len = $urandom_range(1, 11);
            for (int k = 0; k < len; k++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 82)      stream.push_back(hexs[$urandom_range(0, 15)]);
                else if (r < 92) stream.push_back(lows[$urandom_range(0, 5)]);
                else             stream.push_back(bads[$urandom_range(0, 9)]);
            end
            repeat ($urandom_range(1, 2)) stream.push_back(dels[$urandom_range(0, 3)]);
        end
        model(stream);
        rnd_ready = 1'b1;
        foreach (stream[i]) begin
            send_char(stream[i]);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end
        in_valid  = 1'b0;
        rnd_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();
        check("rnd_nwords", 64'(obs_w.size()), 64'(exp_w.size()));
        check("rnd_nerrs", 64'(obs_e.size()), 64'(exp_e.size()));
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++)
            check($sformatf("rnd_word%0d", i), 64'(obs_w[i]), 64'(exp_w[i]));
        for (int i = 0; i < obs_e.size() && i < exp_e.size(); i++)
            check($sformatf("rnd_err%0d", i), 64'(obs_e[i]), 64'(exp_e[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
